deser400_tp_capture: RTL and testbench
======================================

Name: deser400_tp_capture

Overview:
- Downstream consumer of the deser400 test-point mux outputs tpa/tpb.
- Records a 2-bit trace {tpb,tpa} into an on-chip circular buffer around a selectable trigger, so the CPU can read back test-point activity without a scope.
- Also keeps free-running rising-edge counters per test point.
- Runs in the same clk domain as the mux, so the inputs need no synchroniser.

Parameters:
- ADDR_W, 8, buffer address width; depth = 2**ADDR_W samples of 2 bits.
- CNT_W, 16, width of the edge counters.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tpa  input  1  registered test point A from the mux
- tpb  input  1  registered test point B from the mux
- arm  input  1  one-cycle pulse; starts or restarts a capture
- trig_mode  input  2  0: tpa rising; 1: tpa falling; 2: tpb rising; 3: immediate
- post_cnt  input  ADDR_W  number of samples stored after the trigger sample
- rd_addr  input  ADDR_W  buffer read address
- rd_data  output  2  {tpb,tpa} at rd_addr, one cycle latency
- busy  output  1  capture in progress (WAIT_TRIG or POST)
- done  output  1  capture complete, buffer stable
- wrapped  output  1  write pointer wrapped before the trigger
- trig_pos  output  ADDR_W  buffer address holding the trigger sample
- cnt_clr  input  1  synchronous clear of both edge counters
- cnt_a  output  CNT_W  tpa rising-edge count, saturating
- cnt_b  output  CNT_W  tpb rising-edge count, saturating

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, wr_ptr 0, tpa_d and tpb_d 0. Buffer contents are not reset.
- Edge detection:
  - tpa_d and tpb_d register tpa and tpb every cycle.
  - rise_a = tpa & ~tpa_d; fall_a = ~tpa & tpa_d; rise_b = tpb & ~tpb_d.
- Trigger condition trg, per trig_mode: rise_a / fall_a / rise_b / 1.
- FSM states: IDLE, WAIT_TRIG, POST, DONE.
- IDLE:
  - No writes.
  - arm -> WAIT_TRIG; wr_ptr <= 0, done <= 0, wrapped <= 0.
- WAIT_TRIG (busy = 1):
  - Each cycle, write current {tpb,tpa} to mem[wr_ptr], then wr_ptr <= wr_ptr + 1 (mod depth).
  - wrapped <= 1 when a write occurs at wr_ptr = depth-1.
  - If trg in the same cycle, trig_pos <= wr_ptr (the address being written) and remaining <= post_cnt.
  - Next state after trg: DONE if post_cnt == 0, else POST.
- POST (busy = 1):
  - Each cycle, write, increment wr_ptr and decrement remaining.
  - remaining == 1 -> DONE after that write, so exactly post_cnt samples follow the trigger sample.
  - wrapped does not change in POST.
- DONE:
  - done = 1, busy = 0, no writes; trig_pos and wrapped are held.
  - arm -> WAIT_TRIG with the same initialisation as IDLE.
- arm while busy: restart immediately with the IDLE -> WAIT_TRIG initialisation.
  - The sample in the arm cycle is not written; the first write is the cycle after arm.
- trig_mode and post_cnt are sampled only when the trigger fires. Changing them mid-capture affects nothing already fired.
- Trace window:
  - Pre-trigger samples = trig_pos if wrapped = 0; otherwise depth-1-post_cnt valid samples before trig_pos (oldest overwritten).
  - post_cnt >= depth overwrites pre-trigger data; legal but software's responsibility.
- Read port:
  - Synchronous: rd_data <= mem[rd_addr] every cycle, in any state (inferred block RAM).
  - Read-during-write to the same address returns the old data.
- Edge counters:
  - cnt_a += rise_a and cnt_b += rise_b every cycle, in all FSM states.
  - Each counter saturates at 2**CNT_W - 1.
  - cnt_clr has priority: a simultaneous edge is not counted and the counter becomes 0.
- Reset mid-capture: immediate return to IDLE with all outputs 0; the buffer keeps stale data.

Test Plan:
- Reset, then arm with trig_mode = 3 and post_cnt = 4 -> trig_pos = 0, done high 5 cycles after the first write cycle, busy low, mem[0..4] equal to the driven samples.
- trig_mode = 0, tpa held 0 for 10 cycles after arm, then 1, post_cnt = 2 -> trig_pos = 10, wrapped = 0, rd_data at address 10 = 2'b01 one cycle after rd_addr = 10.
- trig_mode = 2, tpb held 0 for 300 cycles (ADDR_W = 8), then rising -> wrapped = 1, trig_pos = 300 mod 256 = 44.
- Arm, then arm again after 5 cycles with no trigger -> wr_ptr restarts at 0, the first write is in the cycle after the second arm, done stays 0.
- Toggle tpa every cycle for 20 cycles -> cnt_a = 10. With CNT_W = 4, 20 rising edges -> cnt_a = 15 (saturated). cnt_clr coincident with a rising edge -> cnt_a = 0.
- Assert reset during POST -> busy, done, trig_pos and wrapped all 0 immediately, FSM in IDLE. A subsequent arm captures normally.

Source files
------------

// File: rtl/deser400_tp_capture_if.sv
// Bundles the test-point capture signals: trace inputs, capture control,
// buffer read port, status and edge counters.
interface deser400_tp_capture_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              tpa;
  logic              tpb;
  logic              arm;
  logic [1:0]        trig_mode;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic [ADDR_W-1:0] trig_pos;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;

  modport master (
    output tpa, tpb, arm, trig_mode, post_cnt, rd_addr, cnt_clr,
    input  rd_data, busy, done, wrapped, trig_pos, cnt_a, cnt_b
  );

  modport slave (
    input  tpa, tpb, arm, trig_mode, post_cnt, rd_addr, cnt_clr,
    output rd_data, busy, done, wrapped, trig_pos, cnt_a, cnt_b
  );
endinterface

// File: rtl/deser400_tp_capture.sv
// Circular trace buffer of {tpb,tpa} captured around a selectable trigger,
// plus saturating rising-edge counters for both test points.
module deser400_tp_capture #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  deser400_tp_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, POST, DONE} state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [ADDR_W-1:0] trig_pos_q;
  logic              busy_q, done_q, wrapped_q;
  logic              tpa_dly_q, tpb_dly_q;
  logic [1:0]        rd_data_q;
  logic [CNT_W-1:0]  cnt_a_q, cnt_b_q;
  logic [1:0]        mem [DEPTH];

  logic rise_a, fall_a, rise_b, trg, we;

  assign rise_a = bus.tpa & ~tpa_dly_q;
  assign fall_a = ~bus.tpa & tpa_dly_q;
  assign rise_b = bus.tpb & ~tpb_dly_q;

  always_comb begin
    trg = 1'b0;
    case (bus.trig_mode)
      2'd0:    trg = rise_a;
      2'd1:    trg = fall_a;
      2'd2:    trg = rise_b;
      default: trg = 1'b1;
    endcase
  end

  // An arm pulse restarts the capture, so the arm-cycle sample is never stored.
  assign we = ((state_q == WAIT_TRIG) || (state_q == POST)) && !bus.arm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      trig_pos_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
    end else if (bus.arm) begin
      state_q   <= WAIT_TRIG;
      wr_ptr_q  <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_TRIG: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (&wr_ptr_q) wrapped_q <= 1'b1;
          if (trg) begin
            trig_pos_q  <= wr_ptr_q;
            remaining_q <= bus.post_cnt;
            if (bus.post_cnt == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= POST;
            end
          end
        end
        POST: begin
          wr_ptr_q    <= wr_ptr_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q == ADDR_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer RAM: write port from the capture FSM, registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= {bus.tpb, bus.tpa};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem[bus.rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tpa_dly_q <= 1'b0;
      tpb_dly_q <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      tpa_dly_q <= bus.tpa;
      tpb_dly_q <= bus.tpb;
      if (bus.cnt_clr) begin
        cnt_a_q <= '0;
        cnt_b_q <= '0;
      end else begin
        cnt_a_q <= sat_inc(cnt_a_q, rise_a);
        cnt_b_q <= sat_inc(cnt_b_q, rise_b);
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.trig_pos = trig_pos_q;
  assign bus.cnt_a    = cnt_a_q;
  assign bus.cnt_b    = cnt_b_q;

endmodule

// File: tb/tb_deser400_tp_capture.sv
// Directed bench for deser400_tp_capture: capture windows, wrap, re-arm,
// edge counters with saturation, and reset during a capture.
module tb_deser400_tp_capture;
  localparam int AW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  deser400_tp_capture_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  deser400_tp_capture #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [1:0] exp);
    bus.rd_addr = AW'(addr);
    step();
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  logic [1:0] s [5];

  initial begin
    s[0] = 2'b01; s[1] = 2'b10; s[2] = 2'b11; s[3] = 2'b00; s[4] = 2'b01;
    reset         = 1'b1;
    bus.tpa       = 1'b0;
    bus.tpb       = 1'b0;
    bus.arm       = 1'b0;
    bus.trig_mode = 2'd0;
    bus.post_cnt  = '0;
    bus.rd_addr   = '0;
    bus.cnt_clr   = 1'b0;
    step();
    step();
    chk("rst_busy",     32'(bus.busy),     0);
    chk("rst_done",     32'(bus.done),     0);
    chk("rst_wrapped",  32'(bus.wrapped),  0);
    chk("rst_trig_pos", 32'(bus.trig_pos), 0);
    chk("rst_cnt_a",    32'(bus.cnt_a),    0);
    chk("rst_cnt_b",    32'(bus.cnt_b),    0);
    chk("rst_rd_data",  32'(bus.rd_data),  0);
    reset = 1'b0;
    step();

    // Immediate trigger, four post samples
    bus.trig_mode = 2'd3;
    bus.post_cnt  = AW'(4);
    bus.arm       = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("t1_busy_armed", 32'(bus.busy), 1);
    for (int i = 0; i < 5; i++) begin
      {bus.tpb, bus.tpa} = s[i];
      step();
      if (i < 4) chk("t1_done_early", 32'(bus.done), 0);
    end
    chk("t1_done",     32'(bus.done),     1);
    chk("t1_busy",     32'(bus.busy),     0);
    chk("t1_trig_pos", 32'(bus.trig_pos), 0);
    {bus.tpb, bus.tpa} = 2'b00;
    for (int i = 0; i < 5; i++) rd_chk("t1_mem", i, s[i]);

    // tpa rising after 10 low samples
    bus.trig_mode = 2'd0;
    bus.post_cnt  = AW'(2);
    bus.arm       = 1'b1;
    step();
    bus.arm = 1'b0;
    repeat (10) step();
    bus.tpa = 1'b1;
    step();
    chk("t2_busy",     32'(bus.busy),     1);
    chk("t2_trig_pos", 32'(bus.trig_pos), 10);
    step();
    chk("t2_done_early", 32'(bus.done), 0);
    step();
    chk("t2_done",    32'(bus.done),    1);
    chk("t2_wrapped", 32'(bus.wrapped), 0);
    rd_chk("t2_mem10", 10, 2'b01);
    rd_chk("t2_mem9",  9,  2'b00);

    // tpb rising after 300 samples, buffer wraps
    bus.tpa       = 1'b0;
    bus.tpb       = 1'b0;
    bus.trig_mode = 2'd2;
    bus.post_cnt  = AW'(1);
    bus.arm       = 1'b1;
    step();
    bus.arm = 1'b0;
    repeat (300) step();
    chk("t3_wrapped_pre", 32'(bus.wrapped), 1);
    chk("t3_busy",        32'(bus.busy),    1);
    bus.tpb = 1'b1;
    step();
    chk("t3_trig_pos", 32'(bus.trig_pos), 44);
    step();
    chk("t3_done",    32'(bus.done),    1);
    chk("t3_wrapped", 32'(bus.wrapped), 1);
    rd_chk("t3_mem44", 44, 2'b10);
    rd_chk("t3_mem43", 43, 2'b00);

    // Re-arm while waiting for a trigger
    bus.tpa       = 1'b0;
    bus.tpb       = 1'b0;
    bus.trig_mode = 2'd0;
    bus.arm       = 1'b1;
    step();
    bus.arm = 1'b0;
    repeat (5) step();
    chk("t4_done_mid", 32'(bus.done), 0);
    {bus.tpb, bus.tpa} = 2'b11;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("t4_busy_rearm", 32'(bus.busy), 1);
    chk("t4_done_rearm", 32'(bus.done), 0);
    {bus.tpb, bus.tpa} = 2'b10;
    repeat (3) step();
    chk("t4_done_wait", 32'(bus.done), 0);
    bus.trig_mode = 2'd3;
    bus.post_cnt  = '0;
    step();
    chk("t4_done",     32'(bus.done),     1);
    chk("t4_trig_pos", 32'(bus.trig_pos), 3);
    rd_chk("t4_mem0", 0, 2'b10);
    rd_chk("t4_mem5", 5, 2'b00);

    // Edge counters
    bus.tpa     = 1'b0;
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    chk("t5_clr", 32'(bus.cnt_a), 0);
    for (int i = 0; i < 20; i++) begin
      bus.tpa = (i % 2 == 0);
      step();
    end
    chk("t5_cnt_a10", 32'(bus.cnt_a), 10);
    chk("t5_cnt_b0",  32'(bus.cnt_b), 0);
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.tpa = (i % 2 == 0);
      step();
    end
    chk("t5_cnt_a_sat", 32'(bus.cnt_a), 15);
    bus.tpa     = 1'b1;
    bus.cnt_clr = 1'b1;
    step();
    chk("t5_clr_edge", 32'(bus.cnt_a), 0);
    bus.cnt_clr = 1'b0;
    bus.tpa     = 1'b0;
    step();
    chk("t5_after_clr", 32'(bus.cnt_a), 0);
    bus.tpb = 1'b0;
    step();
    bus.tpb = 1'b1;
    step();
    chk("t5_cnt_b1", 32'(bus.cnt_b), 1);

    // Reset during POST
    bus.tpa       = 1'b0;
    bus.tpb       = 1'b0;
    bus.trig_mode = 2'd0;
    bus.post_cnt  = AW'(10);
    bus.arm       = 1'b1;
    step();
    bus.arm = 1'b0;
    repeat (3) step();
    bus.tpa = 1'b1;
    step();
    chk("t6_trig_pos", 32'(bus.trig_pos), 3);
    step();
    chk("t6_busy_post", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy",     32'(bus.busy),     0);
    chk("t6_rst_done",     32'(bus.done),     0);
    chk("t6_rst_trig_pos", 32'(bus.trig_pos), 0);
    chk("t6_rst_wrapped",  32'(bus.wrapped),  0);
    chk("t6_rst_cnt_a",    32'(bus.cnt_a),    0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("t6_idle_busy", 32'(bus.busy), 0);
    chk("t6_idle_done", 32'(bus.done), 0);
    bus.trig_mode = 2'd3;
    bus.post_cnt  = AW'(1);
    {bus.tpb, bus.tpa} = 2'b10;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    {bus.tpb, bus.tpa} = 2'b01;
    step();
    chk("t6_re_trig_pos", 32'(bus.trig_pos), 0);
    {bus.tpb, bus.tpa} = 2'b11;
    step();
    chk("t6_re_done", 32'(bus.done), 1);
    rd_chk("t6_mem0", 0, 2'b01);
    rd_chk("t6_mem1", 1, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
